fccc_pll_sequencer: RTL and testbench
=====================================

Name: fccc_pll_sequencer

Overview:
Power-up, reset and lock-supervision sequencer for the fabric CCC PLL driven from the on-chip RC oscillator. Runs on the free-running oscillator clock, never on a PLL output. Drives the PLL powerdown and async-reset pins, qualifies LOCK, and releases a fabric reset only after lock has been stable. Handles Flash*Freeze entry/exit with a drain/ack handshake and bounded relock retries.

Parameters:
PWRUP_CYCLES, 16, cycles PLL_ARST_N held low after powerdown release (range 2..65535)
LOCK_TIMEOUT, 4096, max cycles from ARST release to qualified lock
LOCK_STABLE_CYCLES, 256, consecutive synced-LOCK-high cycles required before RUN
MAX_RETRIES, 3, timeouts tolerated before FAULT (range 1..15)
DRAIN_CYCLES, 8, cycles fabric reset held before PLL powerdown on freeze
CNT_W, 16, width of the internal cycle counters; must hold the largest count parameter

Ports:
CLK  in  1  RC-oscillator-derived free-running clock
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  level; 1 = PLL wanted, 0 = power down
LOCK  in  1  PLL LOCK, asynchronous to CLK
FREEZE_REQ  in  1  level; Flash*Freeze request
PLL_POWERDOWN_N  out  1  to CCC PLL_POWERDOWN_N
PLL_ARST_N  out  1  to CCC PLL_ARST_N
FABRIC_RESET_N  out  1  reset for logic clocked by GL0/GL1
PLL_READY  out  1  1 only in RUN
FREEZE_ACK  out  1  1 only in FROZEN
FAULT  out  1  1 only in FAULT
LOCK_LOST_CNT  out  8  saturating count of lock losses in RUN
STATE  out  3  current state encoding (debug)

Behaviour:
- RESET=1: state OFF; every output is 0, including LOCK_LOST_CNT; counters and retry count are cleared. Reset mid-sequence aborts at once with no drain.
- LOCK passes through a 2-flop synchronizer, giving lock_s (2-cycle latency). All decisions use lock_s.
- All outputs are registered and change on the same edge that enters the state.
- Encodings: OFF=0, PWRUP=1, WAIT_LOCK=2, STABLE=3, RUN=4, DRAIN=5, FROZEN=6, FAULT=7.
- Output decode:
  - PD_N=1 in PWRUP, WAIT_LOCK, STABLE, RUN, DRAIN.
  - ARST_N=1 in WAIT_LOCK, STABLE, RUN, DRAIN.
  - FABRIC_RESET_N=1 only in RUN.
- Transition priority per cycle: (1) ENABLE=0, then (2) FREEZE_REQ=1, then (3) timers/lock.
- ENABLE=0 in any state except FAULT: go to OFF next edge. OFF clears the retry count.
- OFF: if ENABLE=1 and FREEZE_REQ=0, go to PWRUP. If ENABLE=1 and FREEZE_REQ=1, go to FROZEN.
- PWRUP: lasts exactly PWRUP_CYCLES cycles, then WAIT_LOCK. Entry clears the timeout counter.
- WAIT_LOCK: lock_s=1 goes to STABLE.
- STABLE: counts consecutive lock_s=1 cycles. At LOCK_STABLE_CYCLES it goes to RUN. lock_s=0 goes back to WAIT_LOCK and restarts the stability count; the timeout counter is not cleared.
- Timeout counter runs in WAIT_LOCK and STABLE. On reaching LOCK_TIMEOUT, retries increments. If retries < MAX_RETRIES, go to PWRUP (re-pulses ARST); otherwise go to FAULT.
- RUN: entry clears retries.
  - lock_s=0: go to PWRUP; LOCK_LOST_CNT increments and saturates at 255. This does not count as a retry.
  - FREEZE_REQ=1: go to DRAIN.
- DRAIN: lasts exactly DRAIN_CYCLES cycles (fabric in reset, PLL still running), then FROZEN. Lock loss is ignored in DRAIN.
- FREEZE_REQ=1 in PWRUP, WAIT_LOCK or STABLE: go directly to FROZEN, with no drain.
- FROZEN: PLL powered down and reset; FREEZE_ACK=1. When FREEZE_REQ falls, go to PWRUP (ENABLE=1) or OFF (ENABLE=0).
- FAULT: PLL powered down; FREEZE_REQ and LOCK are ignored. Leaves only via ENABLE=0, which goes to OFF.
- LOCK_LOST_CNT is cleared only by RESET.

Test Plan:
Bench parameters: PWRUP_CYCLES=4, LOCK_TIMEOUT=64, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, DRAIN_CYCLES=3.
1. Nominal bring-up: ENABLE=1 at cycle 0, LOCK high from cycle 10 -> PD_N=1 at cycle 1; ARST_N=1 at cycle 5; STABLE entered 2 cycles after LOCK rises; FABRIC_RESET_N=PLL_READY=1 exactly 8 cycles later; FAULT=0.
2. Lock glitch during STABLE: LOCK low for 1 cycle, 5 cycles into STABLE -> return to WAIT_LOCK; RUN reached 8 full lock_s cycles after the glitch clears; FABRIC_RESET_N stays 0 throughout.
3. Lock loss in RUN: drop LOCK for 3 cycles -> FABRIC_RESET_N=0 and ARST_N=0 two cycles after the drop; LOCK_LOST_CNT=1; full resequence back to RUN. Repeat 300 times -> LOCK_LOST_CNT=255.
4. Timeout/retry: LOCK held 0 -> two 64-cycle WAIT_LOCK windows separated by 4-cycle ARST pulses, then FAULT=1, PD_N=0. FREEZE_REQ pulse ignored. ENABLE=0 -> OFF; ENABLE=1 -> new sequence with retries=0.
5. Freeze handshake from RUN: FREEZE_REQ=1 -> FABRIC_RESET_N=0 next edge; PD_N stays 1 for 3 cycles, then PD_N=ARST_N=0 and FREEZE_ACK=1. FREEZE_REQ=0 -> FREEZE_ACK=0 and PWRUP next edge.
6. Simultaneous events and reset: ENABLE=0 and FREEZE_REQ=1 on the same cycle in RUN -> OFF, FREEZE_ACK stays 0. RESET=1 mid-DRAIN -> all outputs 0 next edge.

Source files
------------

// File: rtl/fccc_pll_sequencer.sv
// Power-up, reset and lock-supervision sequencer for a fabric CCC PLL.
// Runs from the free-running RC-oscillator clock. Drives PLL powerdown and
// async reset, qualifies LOCK through a 2-flop synchronizer, holds the fabric
// reset until lock has been stable, and handles Flash*Freeze drain/ack with
// bounded relock retries.
module fccc_pll_sequencer #(
  parameter int unsigned PWRUP_CYCLES       = 16,
  parameter int unsigned LOCK_TIMEOUT       = 4096,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned DRAIN_CYCLES       = 8,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       LOCK,
  input  logic       FREEZE_REQ,
  output logic       PLL_POWERDOWN_N,
  output logic       PLL_ARST_N,
  output logic       FABRIC_RESET_N,
  output logic       PLL_READY,
  output logic       FREEZE_ACK,
  output logic       FAULT,
  output logic [7:0] LOCK_LOST_CNT,
  output logic [2:0] STATE
);

  // State encodings are visible on STATE, so they are fixed values.
  localparam logic [2:0] S_OFF       = 3'd0;
  localparam logic [2:0] S_PWRUP     = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_STABLE    = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;
  localparam logic [2:0] S_FROZEN    = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  // Terminal values of the dwell and timeout counters (last cycle of a window).
  localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [4:0]       RETRY_LIMIT  = 5'(MAX_RETRIES);

  // LOCK synchronizer
  logic             lock_meta_q;
  logic             lock_s_q;

  // Sequencer state and counters
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lost_q, lost_d;

  // Registered outputs
  logic             pd_n_q, pd_n_d;
  logic             arst_n_q, arst_n_d;
  logic             fab_rst_n_q, fab_rst_n_d;
  logic             ready_q, ready_d;
  logic             ack_q, ack_d;
  logic             fault_q, fault_d;

  // Helper decodes
  logic             in_lock_window_q;
  logic             in_lock_window_d;
  logic             tmo_hit;
  logic             dwell_timed;
  logic [3:0]       retry_inc;
  logic             retry_exhausted;

  assign in_lock_window_q = (state_q == S_WAIT_LOCK) || (state_q == S_STABLE);
  assign in_lock_window_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE);
  assign tmo_hit          = in_lock_window_q && (tmo_q == TIMEOUT_LAST);
  assign dwell_timed      = (state_q == S_PWRUP) || (state_q == S_STABLE) ||
                            (state_q == S_DRAIN);
  assign retry_inc        = retry_q + 4'd1;
  assign retry_exhausted  = ({1'b0, retry_q} + 5'd1) >= RETRY_LIMIT;

  // Two-flop synchronizer for the asynchronous PLL LOCK
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= LOCK;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Next-state logic: ENABLE low first, then FREEZE_REQ, then timers/lock.
  // Within WAIT_LOCK/STABLE, reaching the next lock milestone wins over an
  // expiring timeout on the same cycle; the timeout wins over falling back
  // from STABLE to WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    if (!ENABLE && (state_q != S_FAULT)) begin
      state_d = S_OFF;
    end else if (FREEZE_REQ && ((state_q == S_PWRUP) || (state_q == S_WAIT_LOCK) ||
                                (state_q == S_STABLE))) begin
      state_d = S_FROZEN;
    end else if (FREEZE_REQ && (state_q == S_RUN)) begin
      state_d = S_DRAIN;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = FREEZE_REQ ? S_FROZEN : S_PWRUP;
        end
        S_PWRUP: begin
          if (dwell_q == PWRUP_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (tmo_hit) begin
            retry_d = retry_inc;
            state_d = retry_exhausted ? S_FAULT : S_PWRUP;
          end
        end
        S_STABLE: begin
          if (lock_s_q && (dwell_q == STABLE_LAST)) begin
            state_d = S_RUN;
          end else if (tmo_hit) begin
            retry_d = retry_inc;
            state_d = retry_exhausted ? S_FAULT : S_PWRUP;
          end else if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d = S_PWRUP;
            if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
          end
        end
        S_DRAIN: begin
          if (dwell_q == DRAIN_LAST) state_d = S_FROZEN;
        end
        S_FROZEN: begin
          // ENABLE is known high here; ENABLE low was handled above.
          if (!FREEZE_REQ) state_d = S_PWRUP;
        end
        S_FAULT: begin
          if (!ENABLE) state_d = S_OFF;
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end

    // Retry budget is refilled in OFF and on reaching RUN.
    if ((state_d == S_OFF) || (state_d == S_RUN)) retry_d = '0;
  end

  // Counter next values: dwell restarts on every state change; the timeout
  // counter spans WAIT_LOCK and STABLE together and restarts only when the
  // lock window is (re)entered from outside it.
  always_comb begin
    dwell_d = '0;
    tmo_d   = '0;
    if ((state_d == state_q) && dwell_timed) dwell_d = dwell_q + 1'b1;
    if (in_lock_window_d && in_lock_window_q) tmo_d = tmo_q + 1'b1;
  end

  // Output decode from the next state so outputs change on the entering edge
  always_comb begin
    pd_n_d      = 1'b0;
    arst_n_d    = 1'b0;
    fab_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    ack_d       = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      S_PWRUP: begin
        pd_n_d = 1'b1;
      end
      S_WAIT_LOCK, S_STABLE, S_DRAIN: begin
        pd_n_d   = 1'b1;
        arst_n_d = 1'b1;
      end
      S_RUN: begin
        pd_n_d      = 1'b1;
        arst_n_d    = 1'b1;
        fab_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      S_FROZEN: begin
        ack_d = 1'b1;
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        pd_n_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_OFF;
      dwell_q     <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      pd_n_q      <= 1'b0;
      arst_n_q    <= 1'b0;
      fab_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pd_n_q      <= pd_n_d;
      arst_n_q    <= arst_n_d;
      fab_rst_n_q <= fab_rst_n_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      fault_q     <= fault_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign PLL_ARST_N      = arst_n_q;
  assign FABRIC_RESET_N  = fab_rst_n_q;
  assign PLL_READY       = ready_q;
  assign FREEZE_ACK      = ack_q;
  assign FAULT           = fault_q;
  assign LOCK_LOST_CNT   = lost_q;
  assign STATE           = state_q;

endmodule

// File: tb/tb_fccc_pll_sequencer.sv
// Testbench for fccc_pll_sequencer: directed scenarios followed by random
// input segments, every cycle compared against a behavioural model.
module tb_fccc_pll_sequencer;

  localparam int PWRUP   = 4;
  localparam int TIMEOUT = 64;
  localparam int STABLE  = 8;
  localparam int RETRIES = 2;
  localparam int DRAIN   = 3;

  logic       clk = 1'b0;
  logic       rst, en, lk, fr;
  logic       pd_n, arst_n, fab_n, ready, ack, fault;
  logic [7:0] lost;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  fccc_pll_sequencer #(
    .PWRUP_CYCLES      (PWRUP),
    .LOCK_TIMEOUT      (TIMEOUT),
    .LOCK_STABLE_CYCLES(STABLE),
    .MAX_RETRIES       (RETRIES),
    .DRAIN_CYCLES      (DRAIN),
    .CNT_W             (16)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .ENABLE         (en),
    .LOCK           (lk),
    .FREEZE_REQ     (fr),
    .PLL_POWERDOWN_N(pd_n),
    .PLL_ARST_N     (arst_n),
    .FABRIC_RESET_N (fab_n),
    .PLL_READY      (ready),
    .FREEZE_ACK     (ack),
    .FAULT          (fault),
    .LOCK_LOST_CNT  (lost),
    .STATE          (state)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase name as a number, time spent in the phase,
  // time spent trying to lock since ARST release, and a LOCK delay line.
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_trying  = 0;
  int m_retries = 0;
  int m_lost    = 0;
  bit m_hist[$] = {1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ls;
    int nxt;
    bit expired;
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_trying = 0; m_retries = 0; m_lost = 0;
      m_hist = {1'b0, 1'b0};
      return;
    end
    ls      = m_hist[0];
    nxt     = m_phase;
    expired = (m_phase == 2 || m_phase == 3) && (m_trying + 1 == TIMEOUT);
    if (!en && m_phase != 7)                     nxt = 0;
    else if (fr && m_phase >= 1 && m_phase <= 3) nxt = 6;
    else if (fr && m_phase == 4)                 nxt = 5;
    else begin
      case (m_phase)
        0: nxt = fr ? 6 : 1;
        1: if (m_elapsed + 1 == PWRUP) nxt = 2;
        2: if (ls) nxt = 3; else if (expired) nxt = -1;
        3: if (ls && m_elapsed + 1 == STABLE) nxt = 4;
           else if (expired) nxt = -1;
           else if (!ls) nxt = 2;
        4: if (!ls) begin nxt = 1; if (m_lost < 255) m_lost++; end
        5: if (m_elapsed + 1 == DRAIN) nxt = 6;
        6: if (!fr) nxt = 1;
        default: if (!en) nxt = 0;
      endcase
    end
    if (nxt == -1) begin
      m_retries++;
      nxt = (m_retries >= RETRIES) ? 7 : 1;
    end
    if (nxt == 0 || nxt == 4) m_retries = 0;
    m_trying  = ((nxt == 2 || nxt == 3) && (m_phase == 2 || m_phase == 3)) ? m_trying + 1 : 0;
    m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
    m_phase   = nxt;
    void'(m_hist.pop_front());
    m_hist.push_back(lk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", 32'(state), 32'(m_phase));
    chk("pd_n", 32'(pd_n), 32'(m_phase >= 1 && m_phase <= 5));
    chk("arst_n", 32'(arst_n), 32'(m_phase >= 2 && m_phase <= 5));
    chk("fabric_reset_n", 32'(fab_n), 32'(m_phase == 4));
    chk("pll_ready", 32'(ready), 32'(m_phase == 4));
    chk("freeze_ack", 32'(ack), 32'(m_phase == 6));
    chk("fault", 32'(fault), 32'(m_phase == 7));
    chk("lock_lost_cnt", 32'(lost), 32'(m_lost));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; fr = 1'b0; lk = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fr = 1'b0; lk = 1'b0;

    // Reset state
    run(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_pd_n", 32'(pd_n), 0);
    chk("rst_lost", 32'(lost), 0);

    // 1. Nominal bring-up, ENABLE at cycle 0, LOCK sampled from cycle 10
    rst = 1'b0; en = 1'b1;
    run(1);  chk("bringup_pd_at_1", 32'(pd_n), 1);
             chk("bringup_arst_at_1", 32'(arst_n), 0);
    run(3);  chk("bringup_arst_at_4", 32'(arst_n), 0);
    run(1);  chk("bringup_arst_at_5", 32'(arst_n), 1);
    run(4);  lk = 1'b1;
    run(2);  chk("bringup_wait_at_11", 32'(state), 2);
    run(1);  chk("bringup_stable_at_12", 32'(state), 3);
    run(7);  chk("bringup_fab_at_19", 32'(fab_n), 0);
    run(1);  chk("bringup_fab_at_20", 32'(fab_n), 1);
             chk("bringup_ready_at_20", 32'(ready), 1);
             chk("bringup_fault", 32'(fault), 0);

    // 2. Lock glitch five cycles into STABLE
    do_reset(); en = 1'b1;
    run(9);  lk = 1'b1;
    run(3);  chk("glitch_stable_entry", 32'(state), 3);
    run(4);  lk = 1'b0;
    run(1);  lk = 1'b1;
    run(1);  chk("glitch_still_stable", 32'(state), 3);
    run(1);  chk("glitch_back_to_wait", 32'(state), 2);
    run(8);  chk("glitch_stable_pre_run", 32'(state), 3);
             chk("glitch_fab_held", 32'(fab_n), 0);
    run(1);  chk("glitch_run", 32'(state), 4);

    // 3. Lock loss in RUN, then saturation of the loss counter
    lk = 1'b0;
    run(2);  chk("loss_fab_before", 32'(fab_n), 1);
    run(1);  chk("loss_fab_dropped", 32'(fab_n), 0);
             chk("loss_arst_dropped", 32'(arst_n), 0);
             chk("loss_cnt_1", 32'(lost), 1);
    lk = 1'b1;
    run(20); chk("loss_resequenced", 32'(state), 4);
    for (int unsigned i = 0; i < 299; i++) begin
      lk = 1'b0; run(3);
      lk = 1'b1; run(20);
    end
    chk("loss_cnt_saturated", 32'(lost), 255);
    chk("loss_final_run", 32'(state), 4);

    // 4. Timeout, retry, FAULT and recovery
    do_reset(); en = 1'b1;
    run(5);  chk("tmo_first_window", 32'(state), 2);
    run(63); chk("tmo_window_end", 32'(state), 2);
    run(1);  chk("tmo_repulse", 32'(state), 1);
             chk("tmo_repulse_arst", 32'(arst_n), 0);
    run(3);  chk("tmo_repulse_len", 32'(state), 1);
    run(1);  chk("tmo_second_window", 32'(state), 2);
    run(63); chk("tmo_second_end", 32'(state), 2);
    run(1);  chk("tmo_fault", 32'(fault), 1);
             chk("tmo_fault_pd", 32'(pd_n), 0);
    fr = 1'b1;
    run(3);  chk("fault_ignores_freeze", 32'(state), 7);
             chk("fault_no_ack", 32'(ack), 0);
    fr = 1'b0; en = 1'b0;
    run(1);  chk("fault_to_off", 32'(state), 0);
    en = 1'b1;
    run(69); chk("retry_count_cleared", 32'(state), 1);
             chk("retry_no_fault", 32'(fault), 0);

    // 5. Freeze handshake from RUN
    do_reset(); en = 1'b1; lk = 1'b1;
    run(20); chk("frz_in_run", 32'(state), 4);
    fr = 1'b1;
    run(1);  chk("frz_fab_low", 32'(fab_n), 0);
             chk("frz_pd_held", 32'(pd_n), 1);
    run(2);  chk("frz_drain_pd", 32'(pd_n), 1);
    run(1);  chk("frz_ack", 32'(ack), 1);
             chk("frz_pd_off", 32'(pd_n), 0);
             chk("frz_arst_off", 32'(arst_n), 0);
    run(2);  chk("frz_hold", 32'(state), 6);
    fr = 1'b0;
    run(1);  chk("frz_release_ack", 32'(ack), 0);
             chk("frz_release_pwrup", 32'(state), 1);

    // 6. Simultaneous ENABLE low and FREEZE_REQ, then reset mid-DRAIN
    run(20); chk("sim_in_run", 32'(state), 4);
    en = 1'b0; fr = 1'b1;
    run(1);  chk("sim_off", 32'(state), 0);
             chk("sim_no_ack", 32'(ack), 0);
    en = 1'b1; fr = 1'b0;
    run(20); lk = 1'b0;
    run(3);  lk = 1'b1;
    run(20); chk("sim_lost_1", 32'(lost), 1);
    fr = 1'b1;
    run(2);  chk("sim_in_drain", 32'(state), 5);
    rst = 1'b1;
    run(1);  chk("rst_drain_state", 32'(state), 0);
             chk("rst_drain_pd", 32'(pd_n), 0);
             chk("rst_drain_lost", 32'(lost), 0);
    rst = 1'b0; fr = 1'b0;

    // Random segments of held inputs
    for (int unsigned seg = 0; seg < 60; seg++) begin
      en  = ($urandom_range(0, 9) != 0);
      fr  = ($urandom_range(0, 5) == 0);
      lk  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 29) == 0);
      if (rst) begin
        run(1);
        rst = 1'b0;
      end else begin
        run($urandom_range(1, 90));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
